// File: rtl/inst_fetch_sequencer.sv
// Purpose : sequences one instruction fetch (PC->addr, mem read, ldINST, PC++) and decodes the fetched byte.
// Latency : 6 cycles ADDR..DECODE with mem_ack high and STROBE_W=1; each strobe state adds STROBE_W-1.
// Backpr. : READ stalls indefinitely on mem_ack low; EXEC stalls until exec_done; HALT is left only by reset.
//
// Ports:
//   clk, reset_n         clock, async active-low reset
//   run                  level, fetching allowed while high
//   data, mem_ack        memory data bus and its ready flag (mem_ack sampled in READ only)
//   exec_done            pulse from execute sequencer (seen in EXEC only)
//   sel_pc, mem_rd, ld_inst, ld_inc, sel_inc, ld_pc   registered control strobes
//   inst, inst_class, dec_valid, halted               shadow instruction, decoded class, status
module inst_fetch_sequencer #(
    parameter int N        = 8,   // decode uses inst[7:0]; intended for N == 8
    parameter int STROBE_W = 1    // 1..4 cycles per load strobe
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         run,
    input  logic [N-1:0] data,
    input  logic         mem_ack,
    input  logic         exec_done,
    output logic         sel_pc,
    output logic         mem_rd,
    output logic         ld_inst,
    output logic         ld_inc,
    output logic         sel_inc,
    output logic         ld_pc,
    output logic [N-1:0] inst,
    output logic [2:0]   inst_class,
    output logic         dec_valid,
    output logic         halted
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_READ, S_LOAD, S_INC, S_WBPC, S_DECODE, S_EXEC, S_HALT
    } state_t;

    localparam logic [1:0] CNT_LAST = 2'(STROBE_W - 1);
    localparam logic [7:0] OP_HALT  = 8'hAE;

    state_t     state, state_nxt;
    logic [1:0] cnt;
    logic       strobe_last;

    logic sel_pc_d, mem_rd_d, ld_inst_d, ld_inc_d, sel_inc_d, ld_pc_d, dec_valid_d, halted_d;

    // Priority decode: the HALT opcode sits inside the MOV16 pattern, so it is tested first.
    function automatic logic [2:0] decode(input logic [7:0] b);
        logic [2:0] c;
        if (b == OP_HALT) begin
            c = 3'd7;
        end else begin
            casez (b)
                8'b00??????: c = 3'd0;
                8'b01??????: c = 3'd1;
                8'b1000????: c = 3'd2;
                8'b1001????: c = 3'd3;
                8'b1010????: c = 3'd4;
                8'b11??????: c = 3'd5;
                default:     c = 3'd6;
            endcase
        end
        return c;
    endfunction

    assign strobe_last = (cnt == CNT_LAST);

    // Next state, plus the outputs of the state being entered. Registering these
    // gives Moore outputs that are aligned with the state and cannot glitch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (run) state_nxt = S_ADDR;
            S_ADDR:   state_nxt = S_READ;
            S_READ:   if (mem_ack) state_nxt = S_LOAD;
            S_LOAD:   if (strobe_last) state_nxt = S_INC;
            S_INC:    if (strobe_last) state_nxt = S_WBPC;
            S_WBPC:   if (strobe_last) state_nxt = S_DECODE;
            S_DECODE: state_nxt = (inst[7:0] == OP_HALT) ? S_HALT : S_EXEC;
            S_EXEC:   if (exec_done) state_nxt = run ? S_ADDR : S_IDLE;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_IDLE;
        endcase

        sel_pc_d    = 1'b0;
        mem_rd_d    = 1'b0;
        ld_inst_d   = 1'b0;
        ld_inc_d    = 1'b0;
        sel_inc_d   = 1'b0;
        ld_pc_d     = 1'b0;
        dec_valid_d = 1'b0;
        halted_d    = 1'b0;
        case (state_nxt)
            S_ADDR:   sel_pc_d = 1'b1;
            S_READ:   begin sel_pc_d = 1'b1; mem_rd_d = 1'b1; end
            S_LOAD:   begin sel_pc_d = 1'b1; mem_rd_d = 1'b1; ld_inst_d = 1'b1; end
            S_INC:    begin sel_pc_d = 1'b1; ld_inc_d = 1'b1; end
            S_WBPC:   begin sel_inc_d = 1'b1; ld_pc_d = 1'b1; end
            S_DECODE: dec_valid_d = 1'b1;
            S_HALT:   halted_d = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= 2'd0;
            sel_pc     <= 1'b0;
            mem_rd     <= 1'b0;
            ld_inst    <= 1'b0;
            ld_inc     <= 1'b0;
            sel_inc    <= 1'b0;
            ld_pc      <= 1'b0;
            dec_valid  <= 1'b0;
            halted     <= 1'b0;
            inst       <= '0;
            inst_class <= 3'd0;
        end else begin
            state     <= state_nxt;
            sel_pc    <= sel_pc_d;
            mem_rd    <= mem_rd_d;
            ld_inst   <= ld_inst_d;
            ld_inc    <= ld_inc_d;
            sel_inc   <= sel_inc_d;
            ld_pc     <= ld_pc_d;
            dec_valid <= dec_valid_d;
            halted    <= halted_d;

            // Shared strobe counter: restarts on any state change, saturates otherwise
            // so long waits in READ/EXEC cannot wrap it.
            if (state_nxt != state)
                cnt <= 2'd0;
            else if (!strobe_last)
                cnt <= cnt + 2'd1;

            // Capture at the end of the first LOAD cycle, alongside the IR's ldINST.
            if (state == S_LOAD && cnt == 2'd0)
                inst <= data;

            if (state_nxt == S_DECODE && state != S_DECODE)
                inst_class <= decode(inst[7:0]);
        end
    end

endmodule

// File: tb/tb_inst_fetch_sequencer.sv
// Purpose : directed bench for inst_fetch_sequencer at STROBE_W=1 (dut1) and STROBE_W=3 (dut3).
// Latency : expected {inst, class} queued when a fetch is launched, checked when dec_valid pulses.
// Backpr. : waits on DUT events are cycle-bounded; a missed event is reported as a failure.
module tb_inst_fetch_sequencer;

    typedef struct packed {
        logic [7:0] inst;
        logic [2:0] cls;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       run = 1'b0, run3 = 1'b0;
    logic       mem_ack = 1'b0;
    logic       exec_done = 1'b0, exec_done3 = 1'b0;
    logic [7:0] data = 8'h00;

    logic       sel_pc1, mem_rd1, ld_inst1, ld_inc1, sel_inc1, ld_pc1, dv1, halted1;
    logic [7:0] inst1;
    logic [2:0] class1;
    logic       sel_pc3, mem_rd3, ld_inst3, ld_inc3, sel_inc3, ld_pc3, dv3, halted3;
    logic [7:0] inst3;
    logic [2:0] class3;

    int   total = 0;
    int   bad   = 0;
    exp_t q1[$];
    exp_t q3[$];

    always #5 clk = ~clk;

    inst_fetch_sequencer #(.N(8), .STROBE_W(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .run(run), .data(data), .mem_ack(mem_ack),
        .exec_done(exec_done), .sel_pc(sel_pc1), .mem_rd(mem_rd1), .ld_inst(ld_inst1),
        .ld_inc(ld_inc1), .sel_inc(sel_inc1), .ld_pc(ld_pc1), .inst(inst1),
        .inst_class(class1), .dec_valid(dv1), .halted(halted1)
    );

    inst_fetch_sequencer #(.N(8), .STROBE_W(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .run(run3), .data(data), .mem_ack(mem_ack),
        .exec_done(exec_done3), .sel_pc(sel_pc3), .mem_rd(mem_rd3), .ld_inst(ld_inst3),
        .ld_inc(ld_inc3), .sel_inc(sel_inc3), .ld_pc(ld_pc3), .inst(inst3),
        .inst_class(class3), .dec_valid(dv3), .halted(halted3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_exec1();
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
    endtask

    // Records per-cycle output bits; bit i is the value after the (i+1)-th edge.
    task automatic trace(input bit d3, input int n,
                         output logic [15:0] sp, output logic [15:0] mr, output logic [15:0] li,
                         output logic [15:0] lc, output logic [15:0] lp, output logic [15:0] si,
                         output logic [15:0] dv);
        sp = '0; mr = '0; li = '0; lc = '0; lp = '0; si = '0; dv = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (d3) begin
                sp[i] = sel_pc3; mr[i] = mem_rd3; li[i] = ld_inst3;
                lc[i] = ld_inc3; lp[i] = ld_pc3;  si[i] = sel_inc3; dv[i] = dv3;
            end else begin
                sp[i] = sel_pc1; mr[i] = mem_rd1; li[i] = ld_inst1;
                lc[i] = ld_inc1; lp[i] = ld_pc1;  si[i] = sel_inc1; dv[i] = dv1;
            end
        end
    endtask

    task automatic wait_dec1();
        bit seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            tick();
            if (dv1) seen = 1'b1;
        end
        chk("dec1_seen", 32'(seen), 1);
    endtask

    // Invariants on both DUTs plus the scoreboard drain on every dec_valid.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            chk("strobe_excl1", 32'($onehot0({ld_inst1, ld_inc1, ld_pc1})), 1);
            chk("sel_excl1", 32'(!(sel_pc1 && sel_inc1)), 1);
            chk("strobe_excl3", 32'($onehot0({ld_inst3, ld_inc3, ld_pc3})), 1);
            chk("sel_excl3", 32'(!(sel_pc3 && sel_inc3)), 1);
            if (dv1) begin
                chk("sb1_nonempty", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    chk("inst1", 32'(inst1), 32'(e.inst));
                    chk("class1", 32'(class1), 32'(e.cls));
                end
            end
            if (dv3) begin
                chk("sb3_nonempty", 32'(q3.size() != 0), 1);
                if (q3.size() != 0) begin
                    e = q3.pop_front();
                    chk("inst3", 32'(inst3), 32'(e.inst));
                    chk("class3", 32'(class3), 32'(e.cls));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sp, mr, li, lc, lp, si, dv;
        logic [7:0]  sweep_v [7];
        logic [2:0]  sweep_c [7];
        logic [7:0]  acc;
        int          hold;

        sweep_v = '{8'h00, 8'h40, 8'h82, 8'h95, 8'hA3, 8'hC0, 8'hB0};
        sweep_c = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};

        // Reset state
        repeat (3) tick();
        chk("rst_out1", 32'({sel_pc1, mem_rd1, ld_inst1, ld_inc1, sel_inc1, ld_pc1, dv1, halted1}), 0);
        chk("rst_inst1", 32'(inst1), 0);
        chk("rst_class1", 32'(class1), 0);
        chk("rst_out3", 32'({sel_pc3, mem_rd3, ld_inst3, ld_inc3, sel_inc3, ld_pc3, dv3, halted3}), 0);
        reset_n = 1'b1;
        tick(); tick();
        chk("idle_no_run", 32'(sel_pc1), 0);

        // STROBE_W=3: 12-cycle fetch, each load strobe 3 cycles
        mem_ack = 1'b1;
        data = 8'h40;
        q3.push_back('{8'h40, 3'd1});
        run3 = 1'b1;
        trace(1'b1, 12, sp, mr, li, lc, lp, si, dv);
        chk("w3_sel_pc", 32'(sp), 32'h0FF);
        chk("w3_mem_rd", 32'(mr), 32'h01E);
        chk("w3_ld_inst", 32'(li), 32'h01C);
        chk("w3_ld_inc", 32'(lc), 32'h0E0);
        chk("w3_ld_pc", 32'(lp), 32'h700);
        chk("w3_sel_inc", 32'(si), 32'h700);
        chk("w3_dec", 32'(dv), 32'h800);
        run3 = 1'b0;
        tick();
        exec_done3 = 1'b1; tick(); exec_done3 = 1'b0;
        tick(); tick();
        chk("w3_idle", 32'(sel_pc3), 0);

        // Basic fetch, STROBE_W=1
        data = 8'h45;
        q1.push_back('{8'h45, 3'd1});
        run = 1'b1;
        trace(1'b0, 6, sp, mr, li, lc, lp, si, dv);
        chk("w1_sel_pc", 32'(sp), 32'h0F);
        chk("w1_mem_rd", 32'(mr), 32'h06);
        chk("w1_ld_inst", 32'(li), 32'h04);
        chk("w1_ld_inc", 32'(lc), 32'h08);
        chk("w1_ld_pc", 32'(lp), 32'h10);
        chk("w1_sel_inc", 32'(si), 32'h10);
        chk("w1_dec", 32'(dv), 32'h20);
        // exec_done during DECODE must not be seen
        exec_done = 1'b1; tick(); exec_done = 1'b0;
        tick(); tick();
        chk("exec_done_in_decode", 32'(sel_pc1), 0);
        run = 1'b0;
        pulse_exec1();
        hold = 0;
        repeat (3) begin tick(); hold += int'(sel_pc1); end
        chk("idle_after_exec", 32'(hold), 0);

        // Wait states in READ
        mem_ack = 1'b0;
        data = 8'h82;
        q1.push_back('{8'h82, 3'd2});
        run = 1'b1;
        tick();
        chk("ws_addr", 32'({sel_pc1, mem_rd1}), 32'h2);
        hold = 0;
        repeat (5) begin
            tick();
            if (sel_pc1 && mem_rd1 && !ld_inst1) hold++;
        end
        chk("ws_hold", 32'(hold), 5);
        mem_ack = 1'b1;
        tick();
        chk("ws_ld_inst", 32'(ld_inst1), 1);
        wait_dec1();
        tick();
        pulse_exec1();

        // Class sweep, back-to-back fetches with run held high
        for (int i = 0; i < 7; i++) begin
            data = sweep_v[i];
            q1.push_back('{sweep_v[i], sweep_c[i]});
            wait_dec1();
            tick();
            pulse_exec1();
        end
        data = 8'hAE;
        q1.push_back('{8'hAE, 3'd7});
        wait_dec1();
        tick();
        chk("halted", 32'(halted1), 1);
        acc = '0;
        for (int i = 0; i < 10; i++) begin
            exec_done = 1'(i);
            tick();
            acc |= {1'b0, sel_pc1, mem_rd1, ld_inst1, ld_inc1, sel_inc1, ld_pc1, dv1};
        end
        exec_done = 1'b0;
        chk("halt_quiet", 32'(acc), 0);
        chk("halt_held", 32'(halted1), 1);
        chk("halt_class", 32'(class1), 7);

        // Async reset out of HALT clears everything without a clock edge
        run = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("arst_halted", 32'(halted1), 0);
        chk("arst_inst", 32'(inst1), 0);
        chk("arst_class", 32'(class1), 0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_idle", 32'({sel_pc1, mem_rd1, ld_inst1, ld_inc1, sel_inc1, ld_pc1, dv1, halted1}), 0);

        // Reset asserted mid-LOAD
        data = 8'hC0;
        run = 1'b1;
        tick(); tick(); tick();
        chk("pre_rst_load", 32'(ld_inst1), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_load_strobes", 32'({sel_pc1, mem_rd1, ld_inst1}), 0);
        chk("rst_load_inst", 32'(inst1), 0);
        run = 1'b0;
        reset_n = 1'b1;
        tick(); tick();
        chk("rst_load_idle", 32'(sel_pc1), 0);

        // run dropped during INC: fetch completes, then IDLE
        data = 8'h95;
        q1.push_back('{8'h95, 3'd3});
        run = 1'b1;
        repeat (4) tick();
        chk("drop_inc", 32'(ld_inc1), 1);
        run = 1'b0;
        tick();
        chk("drop_wbpc", 32'({sel_inc1, ld_pc1}), 32'h3);
        wait_dec1();
        tick();
        pulse_exec1();
        hold = 0;
        repeat (4) begin tick(); hold += int'(sel_pc1); end
        chk("drop_no_addr", 32'(hold), 0);
        data = 8'hA3;
        q1.push_back('{8'hA3, 3'd4});
        run = 1'b1;
        tick();
        chk("rerun_addr", 32'(sel_pc1), 1);
        wait_dec1();
        run = 1'b0;
        tick();
        pulse_exec1();
        tick();

        chk("q1_drained", 32'(q1.size()), 0);
        chk("q3_drained", 32'(q3.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
